// File: rtl/vx_ahb_mem_arbiter.sv
// vx_ahb_mem_arbiter
// Shares the single-transaction memory port in front of the AHB bridge
// adapter between NUM_REQS requesters. One requester is granted, its
// request is registered and issued downstream, the block waits for the
// completion, and a read response goes back to the owner. The adapter
// returns no tag, so the tag comes from the local register.
//
// Optional feature macro: VX_AHB_MEM_ARB_RR_EN
//   defined   -> round-robin arbitration starting after the last grant
//   undefined -> fixed priority, lowest index wins (no last_grant state)
//
// Handshake rule on every interface: a transfer happens in a cycle where
// valid and ready are both 1. A requester that is not granted sees ready=0
// and keeps its valid and payload unchanged.
//
// dbg_state mirrors the FSM state (0=ARB, 1=ISSUE, 2=WAIT).
module vx_ahb_mem_arbiter #(
    parameter int NUM_REQS     = 4,
    parameter int DATA_WIDTH   = 512,
    parameter int ADDR_WIDTH   = 26,
    parameter int TAG_WIDTH    = 8,
    parameter int BYTEEN_WIDTH = DATA_WIDTH / 8
) (
    input  logic                               clk,
    input  logic                               reset,

    // upstream requests
    input  logic [NUM_REQS-1:0]                req_valid,
    input  logic [NUM_REQS-1:0]                req_rw,
    input  logic [NUM_REQS*BYTEEN_WIDTH-1:0]   req_byteen,
    input  logic [NUM_REQS*ADDR_WIDTH-1:0]     req_addr,
    input  logic [NUM_REQS*DATA_WIDTH-1:0]     req_data,
    input  logic [NUM_REQS*TAG_WIDTH-1:0]      req_tag,
    output logic [NUM_REQS-1:0]                req_ready,

    // upstream responses
    output logic [NUM_REQS-1:0]                rsp_valid,
    output logic [DATA_WIDTH-1:0]              rsp_data,
    output logic [TAG_WIDTH-1:0]               rsp_tag,
    input  logic [NUM_REQS-1:0]                rsp_ready,

    // downstream request
    output logic                               mem_req_valid,
    output logic                               mem_req_rw,
    output logic [BYTEEN_WIDTH-1:0]            mem_req_byteen,
    output logic [ADDR_WIDTH-1:0]              mem_req_addr,
    output logic [DATA_WIDTH-1:0]              mem_req_data,
    output logic [TAG_WIDTH-1:0]               mem_req_tag,
    input  logic                               mem_req_ready,

    // downstream completion
    input  logic                               mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]              mem_rsp_data,
    output logic                               mem_rsp_ready,

    // FSM state for checkers
    output logic [1:0]                         dbg_state
);

    localparam int IDX_W = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;

    typedef enum logic [1:0] {
        ST_ARB   = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t                    state_q,  state_d;
    logic                      rw_q,     rw_d;
    logic [BYTEEN_WIDTH-1:0]   byteen_q, byteen_d;
    logic [ADDR_WIDTH-1:0]     addr_q,   addr_d;
    logic [DATA_WIDTH-1:0]     data_q,   data_d;
    logic [TAG_WIDTH-1:0]      tag_q,    tag_d;
    logic [IDX_W-1:0]          owner_q,  owner_d;

    // winner of the current arbitration round
    logic                      gnt_found;
    logic [IDX_W-1:0]          gnt_idx;
    // a grant is actually taken this cycle; reset is folded in so that no
    // req_ready can show while reset is held, even with requests pending
    logic                      grant_fire;

    assign grant_fire = (state_q == ST_ARB) && reset && gnt_found;

`ifdef VX_AHB_MEM_ARB_RR_EN
    logic [IDX_W-1:0]          last_grant_q, last_grant_d;

    // round-robin pick: scan from last_grant+1, wrapping past NUM_REQS-1
    always_comb begin : rr_pick
        int               idx;
        logic [IDX_W-1:0] idx_v;
        idx       = 0;
        idx_v     = '0;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = 0; k < NUM_REQS; k++) begin
            idx   = (int'(last_grant_q) + 1 + k) % NUM_REQS;
            idx_v = IDX_W'(idx);
            if (!gnt_found && req_valid[idx_v]) begin
                gnt_found = 1'b1;
                gnt_idx   = idx_v;
            end
        end
    end

    // remember the winner only when a grant is taken
    always_comb begin
        last_grant_d = last_grant_q;
        if (grant_fire) begin
            last_grant_d = gnt_idx;
        end
    end

    // round-robin pointer; starts at NUM_REQS-1 so port 0 goes first
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant_q <= IDX_W'(NUM_REQS - 1);
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`else
    // fixed priority pick: lowest requesting index wins
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = 0; k < NUM_REQS; k++) begin
            if (!gnt_found && req_valid[IDX_W'(k)]) begin
                gnt_found = 1'b1;
                gnt_idx   = IDX_W'(k);
            end
        end
    end
`endif

    // next state, request capture and upstream/downstream handshakes
    always_comb begin
        state_d       = state_q;
        rw_d          = rw_q;
        byteen_d      = byteen_q;
        addr_d        = addr_q;
        data_d        = data_q;
        tag_d         = tag_q;
        owner_d       = owner_q;
        req_ready     = '0;
        rsp_valid     = '0;
        rsp_data      = '0;
        mem_rsp_ready = 1'b0;

        case (state_q)
            ST_ARB: begin
                if (grant_fire) begin
                    req_ready[gnt_idx] = 1'b1;
                    rw_d     = req_rw[gnt_idx];
                    byteen_d = req_byteen[int'(gnt_idx)*BYTEEN_WIDTH +: BYTEEN_WIDTH];
                    addr_d   = req_addr[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
                    data_d   = req_data[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
                    tag_d    = req_tag[int'(gnt_idx)*TAG_WIDTH +: TAG_WIDTH];
                    owner_d  = gnt_idx;
                    state_d  = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                // payload comes straight from the registers, so it stays
                // stable for as long as the adapter stalls
                if (mem_req_ready) begin
                    state_d = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (!rw_q) begin
                    // read data and handshake pass through with no delay
                    rsp_valid[owner_q] = mem_rsp_valid;
                    rsp_data           = mem_rsp_data;
                    mem_rsp_ready      = rsp_ready[owner_q];
                    if (mem_rsp_valid && rsp_ready[owner_q]) begin
                        state_d = ST_ARB;
                    end
                end else begin
                    // write completions are consumed locally
                    mem_rsp_ready = 1'b1;
                    if (mem_rsp_valid) begin
                        state_d = ST_ARB;
                    end
                end
            end

            default: begin
                state_d = ST_ARB;
            end
        endcase
    end

    // state and request registers; reset abandons any transaction in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_ARB;
            rw_q     <= 1'b0;
            byteen_q <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            tag_q    <= '0;
            owner_q  <= '0;
        end else begin
            state_q  <= state_d;
            rw_q     <= rw_d;
            byteen_q <= byteen_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            tag_q    <= tag_d;
            owner_q  <= owner_d;
        end
    end

    // downstream request is a pure function of registers; the tag is
    // carried for debug only, the adapter never echoes it
    assign mem_req_valid  = (state_q == ST_ISSUE);
    assign mem_req_rw     = rw_q;
    assign mem_req_byteen = byteen_q;
    assign mem_req_addr   = addr_q;
    assign mem_req_data   = data_q;
    assign mem_req_tag    = tag_q;

    assign rsp_tag        = tag_q;
    assign dbg_state      = state_q;

endmodule
